// File: rtl/decode_block.sv
// Decode/issue stage: decodes 16-bit instructions, reads an 8x16 register file with writeback,
// tracks in-flight destinations on a busy scoreboard and stalls on RAW/WAW hazards.
module decode_block #(
    parameter int unsigned DATA_W = 16,
    parameter logic [5:0]  NOP_OP = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              ex_ready,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              dec_valid,
    output logic [5:0]        op_dec,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        dest_addr
);

    localparam int unsigned NREG = 8;

    logic [DATA_W-1:0] r_rf [NREG];
    logic [NREG-1:0]   r_busy;
    logic              r_dec_valid;
    logic [5:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_dest;

    logic [5:0]        w_opcode;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic              w_is_r;
    logic [DATA_W-1:0] w_imm_ext;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_busy_eff;
    logic              w_hazard;
    logic              w_accept;
    logic              w_issue;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    assign w_opcode  = instr_in[15:10];
    assign w_rd      = instr_in[9:7];
    assign w_rs      = instr_in[6:4];
    assign w_rt      = instr_in[3:1];
    assign w_is_r    = ~w_opcode[5];
    assign w_imm_ext = {{(DATA_W-4){instr_in[3]}}, instr_in[3:0]};

    // Hazard sees busy bits already released by this cycle's writeback.
    always_comb begin
        w_clr = '0;
        if (wb_en && wb_addr != 3'd0) begin
            w_clr[wb_addr] = 1'b1;
        end
    end

    assign w_busy_eff  = r_busy & ~w_clr;
    assign w_hazard    = w_busy_eff[w_rs] | (w_is_r & w_busy_eff[w_rt]) | w_busy_eff[w_rd];
    assign instr_ready = ~w_hazard & (~r_dec_valid | ex_ready);
    assign w_accept    = instr_valid & instr_ready;
    assign w_issue     = w_accept & (w_opcode != NOP_OP);

    always_comb begin
        w_set = '0;
        if (w_issue && w_rd != 3'd0) begin
            w_set[w_rd] = 1'b1;
        end
    end

    // Register reads with same-cycle writeback bypass; r0 is hardwired to zero.
    always_comb begin
        w_rs_val = r_rf[w_rs];
        if (w_rs == 3'd0) begin
            w_rs_val = '0;
        end else if (wb_en && wb_addr == w_rs) begin
            w_rs_val = wb_data;
        end
        w_rt_val = r_rf[w_rt];
        if (w_rt == 3'd0) begin
            w_rt_val = '0;
        end else if (wb_en && wb_addr == w_rt) begin
            w_rt_val = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_busy      <= '0;
            r_dec_valid <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_dest      <= '0;
        end else begin
            if (wb_en && wb_addr != 3'd0) begin
                r_rf[wb_addr] <= wb_data;
            end
            // Set on issue wins over a same-cycle writeback clear.
            r_busy <= w_busy_eff | w_set;
            if (w_issue) begin
                r_dec_valid <= 1'b1;
                r_op        <= w_opcode;
                r_dest      <= w_rd;
                r_a         <= w_rs_val;
                r_b         <= w_is_r ? w_rt_val : w_imm_ext;
            end else if (ex_ready) begin
                r_dec_valid <= 1'b0;
            end
        end
    end

    assign dec_valid = r_dec_valid;
    assign op_dec    = r_op;
    assign A         = r_a;
    assign B         = r_b;
    assign dest_addr = r_dest;

endmodule

// File: tb/tb_decode_block.sv
// Self-checking bench for decode_block: directed scenarios plus randomized traffic compared
// against an instruction-level reference model of the register file and scoreboard.
module tb_decode_block;

    logic        clk;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        ex_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        dec_valid;
    logic [5:0]  op_dec;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  dest_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_rf [8];
    bit          m_busy [8];
    bit          m_valid;
    logic [5:0]  m_op;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [2:0]  m_dest;

    decode_block #(
        .DATA_W (16),
        .NOP_OP (6'h3F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ex_ready    (ex_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .dec_valid   (dec_valid),
        .op_dec      (op_dec),
        .A           (A),
        .B           (B),
        .dest_addr   (dest_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_rf[i]   = 16'h0;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_op    = 6'h0;
        m_a     = 16'h0;
        m_b     = 16'h0;
        m_dest  = 3'h0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] x, input logic we,
                                           input logic [2:0] wa, input logic [15:0] wd);
        if (x == 3'd0) return 16'h0;
        if (we && wa == x) return wd;
        return m_rf[x];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(dec_valid), 32'(m_valid));
        check({tag, ".op"}, 32'(op_dec), 32'(m_op));
        check({tag, ".A"}, 32'(A), 32'(m_a));
        check({tag, ".B"}, 32'(B), 32'(m_b));
        check({tag, ".dest"}, 32'(dest_addr), 32'(m_dest));
    endtask

    // Drive one cycle from a negedge, check ready, advance model, check outputs after the edge.
    task automatic step(input string tag, input logic v, input logic [15:0] ins, input logic exr,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd);
        logic [5:0]  op;
        logic [2:0]  rd, rs, rt;
        bit          bz [8];
        bit          haz, rdy, iss;
        logic [15:0] na, nb;
        instr_valid = v;
        instr_in    = ins;
        ex_ready    = exr;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        op = ins[15:10];
        rd = ins[9:7];
        rs = ins[6:4];
        rt = ins[3:1];
        for (int i = 0; i < 8; i++) bz[i] = m_busy[i] && !(we && wa == 3'(i) && i != 0);
        haz = bz[rs] || (!op[5] && bz[rt]) || bz[rd];
        rdy = !haz && (!m_valid || exr);
        iss = v && rdy && (op != 6'h3F);
        na  = m_read(rs, we, wa, wd);
        nb  = op[5] ? {{12{ins[3]}}, ins[3:0]} : m_read(rt, we, wa, wd);
        #1;
        check({tag, ".ready"}, 32'(instr_ready), 32'(rdy));
        @(posedge clk);
        if (we && wa != 3'd0) m_rf[wa] = wd;
        for (int i = 0; i < 8; i++) m_busy[i] = bz[i];
        if (iss && rd != 3'd0) m_busy[rd] = 1'b1;
        if (iss) begin
            m_valid = 1'b1;
            m_op    = op;
            m_dest  = rd;
            m_a     = na;
            m_b     = nb;
        end else if (exr) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr_in    = 16'h00A6;
        ex_ready    = 1'b1;
        wb_en       = 1'b0;
        wb_addr     = 3'd0;
        wb_data     = 16'h0;
        model_reset();
        #2 reset = 1'b0;

        // Reset held for 3 cycles with a valid instruction presented
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 32'(dec_valid), 32'd0);
        check("rst.A", 32'(A), 32'd0);
        check("rst.B", 32'(B), 32'd0);
        check("rst.op", 32'(op_dec), 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b0;
        #1;
        check("rst.ready", 32'(instr_ready), 32'd1);
        @(negedge clk);

        // Writeback then issue
        step("wb2", 1'b0, 16'h0000, 1'b1, 1'b1, 3'd2, 16'h4000);
        step("wb3", 1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 16'hC000);
        step("iss1", 1'b1, 16'h00A6, 1'b1, 1'b0, 3'd0, 16'h0);
        check("iss1.A_abs", 32'(A), 32'h4000);
        check("iss1.B_abs", 32'(B), 32'hC000);
        check("iss1.dest_abs", 32'(dest_addr), 32'd1);

        // RAW stall on r1, released by bypassed writeback
        step("raw0", 1'b1, 16'h0594, 1'b1, 1'b0, 3'd0, 16'h0);
        step("raw1", 1'b1, 16'h0594, 1'b1, 1'b0, 3'd0, 16'h0);
        instr_valid = 1'b1;
        instr_in    = 16'h0594;
        wb_en       = 1'b1;
        wb_addr     = 3'd1;
        wb_data     = 16'h1234;
        #1;
        check("raw.ready_abs", 32'(instr_ready), 32'd1);
        step("raw2", 1'b1, 16'h0594, 1'b1, 1'b1, 3'd1, 16'h1234);
        check("raw.A_abs", 32'(A), 32'h1234);
        check("raw.B_abs", 32'(B), 32'h4000);

        // Immediate
        step("imm", 1'b1, 16'h810F, 1'b1, 1'b0, 3'd0, 16'h0);
        check("imm.A_abs", 32'(A), 32'h0);
        check("imm.B_abs", 32'(B), 32'hFFFF);
        check("imm.op_abs", 32'(op_dec), 32'h20);
        check("imm.dest_abs", 32'(dest_addr), 32'd2);

        // Backpressure: op 2, rd4, rs5, rt6 waits, then issues
        for (int i = 0; i < 4; i++) begin
            step("bp", 1'b1, 16'h0A5C, 1'b0, 1'b0, 3'd0, 16'h0);
            check("bp.B_abs", 32'(B), 32'hFFFF);
            check("bp.op_abs", 32'(op_dec), 32'h20);
        end
        step("bp.go", 1'b1, 16'h0A5C, 1'b1, 1'b0, 3'd0, 16'h0);
        check("bp.go.op_abs", 32'(op_dec), 32'h02);
        check("bp.go.dest_abs", 32'(dest_addr), 32'd4);

        // r0 ignores writes, even with a same-cycle write
        step("r0wb", 1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 16'hFFFF);
        step("r0rd", 1'b1, 16'h0E80, 1'b1, 1'b1, 3'd0, 16'hFFFF);
        check("r0.A_abs", 32'(A), 32'h0);

        // Reset during a RAW stall on r5
        step("rs0", 1'b1, 16'h1350, 1'b1, 1'b0, 3'd0, 16'h0);
        check("rs0.ready_abs", 32'(instr_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst.valid", 32'(dec_valid), 32'd0);
        check("midrst.dest", 32'(dest_addr), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step("rs1", 1'b1, 16'h1350, 1'b1, 1'b0, 3'd0, 16'h0);
        check("rs1.valid_abs", 32'(dec_valid), 32'd1);
        check("rs1.op_abs", 32'(op_dec), 32'h04);
        check("rs1.dest_abs", 32'(dest_addr), 32'd6);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [5:0]  op;
            logic [15:0] ins;
            op  = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom);
            ins = {op, 10'($urandom)};
            step("rnd", $urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                 1'($urandom), 3'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_block.md
Name: decode_block

Overview:
- Decode/issue stage that feeds execution_block.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and reads an 8x16 register file with a writeback port.
- Tracks in-flight destination registers with a busy scoreboard and stalls on hazards.
- Presents registered op_dec, A and B operands, plus destination info, to execution_block.

Parameters:
- DATA_W, 16, width of register file entries, A, B and wb_data.
- NOP_OP, 6'h3F, opcode consumed without issuing.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- instr_in  input  16  instruction word from fetch.
- instr_valid  input  1  instr_in valid.
- instr_ready  output  1  decode accepts instr_in this cycle.
- ex_ready  input  1  execution stage can take new operands.
- wb_en  input  1  register writeback strobe.
- wb_addr  input  3  writeback register index.
- wb_data  input  DATA_W  writeback value.
- dec_valid  output  1  op_dec/A/B/dest valid.
- op_dec  output  6  opcode to execution_block.
- A  output  DATA_W  operand A.
- B  output  DATA_W  operand B.
- dest_addr  output  3  destination register of the issued op.

Behaviour:
- Encoding: opcode = instr[15:10], rd = [9:7], rs = [6:4].
  - R-type (opcode[5]=0): rt = [3:1], bit 0 ignored.
  - I-type (opcode[5]=1): imm = [3:0], sign-extended to DATA_W.
- op_dec carries the opcode unchanged.
- Reset (reset=0, async):
  - All 8 registers = 0, busy[7:0] = 0.
  - dec_valid = 0; op_dec, A, B, dest_addr = 0.
  - Applies immediately, including mid-stall; pending busy bits are discarded.
- r0 always reads 0, is never busy, and ignores writes.
- Writeback: on a clk edge with wb_en=1 and wb_addr!=0, rf[wb_addr] <= wb_data and busy[wb_addr] <= 0.
- Same-cycle bypass: a read of register x returns wb_data when wb_en && wb_addr==x && x!=0.
- Hazard is evaluated with busy bits already cleared by this cycle's wb_en. It asserts when any of:
  - busy[rs];
  - R-type && busy[rt];
  - busy[rd] (WAW).
- instr_ready = !hazard && (!dec_valid || ex_ready). It is combinational and asserted even when instr_valid=0.
- Issue = instr_valid && instr_ready && opcode!=NOP_OP. Latency 1 cycle; at the next edge:
  - dec_valid <= 1, op_dec <= opcode, dest_addr <= rd;
  - A <= read(rs);
  - B <= read(rt) for R-type, sign-extended imm for I-type;
  - busy[rd] <= 1 if rd!=0.
- Set/clear conflict: busy set on issue and a clear from wb_en for the same register in the same cycle → set wins.
- NOP accepted (instr_valid && instr_ready && opcode==NOP_OP): consumed with no register or busy change; dec_valid <= 0 if ex_ready.
- No issue and ex_ready=1 → dec_valid <= 0; other outputs keep their last values.
- Backpressure (dec_valid && !ex_ready): op_dec, A, B, dest_addr and dec_valid hold; instr_ready=0.
- Write ordering: wb_en writes are independent of stalls and take effect every cycle. A write to a non-busy register is legal and updates rf.

Test Plan:
- Reset: hold reset=0 for 3 cycles while driving instr_valid=1 and instr_in=16'h00A6.
  - Response: dec_valid=0, A=B=0, op_dec=0.
  - After release with ex_ready=1: instr_ready=1.
- Writeback then issue:
  - Stimulus: wb r2=16'h4000, then r3=16'hC000; issue 16'h00A6 (op 0, rd1, rs2, rt3).
  - Next cycle: dec_valid=1, op_dec=0, A=16'h4000, B=16'hC000, dest_addr=1; busy[1]=1.
- RAW stall with bypass:
  - Stimulus: present 16'h0594 (op 1, rd3, rs1, rt2) while busy[1] is set.
  - instr_ready=0 for every cycle until wb_en=1, wb_addr=1, wb_data=16'h1234.
  - In that cycle instr_ready=1; next cycle A=16'h1234, B=16'h4000.
- Immediate: issue 16'h810F (op 32, rd2, rs0, imm F).
  - Response: A=0, B=16'hFFFF, op_dec=6'h20, dest_addr=2.
- Backpressure: with dec_valid=1, drive ex_ready=0 for 4 cycles with a new instruction valid.
  - Response: outputs are unchanged and instr_ready=0 throughout.
  - Raising ex_ready issues the waiting instruction on the next edge.
- r0 and reset mid-stall:
  - wb_en to r0 with 16'hFFFF → a later read of r0 gives A=0.
  - Assert reset during a RAW stall → busy is cleared and the stalled instruction issues immediately after release.
